// File: rtl/block_scheduler_pkg.sv
// Shared types and helpers for the thread-block scheduler.
// Holds the top-level FSM encoding and a popcount used for retirement.
package block_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sched_state_t;

  localparam int MAX_CORES = 32;
  localparam int POP_W = $clog2(MAX_CORES) + 1;

  function automatic logic [POP_W-1:0] popcount(
    input logic [MAX_CORES-1:0] v
  );
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_CORES; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/block_scheduler_rr_picker.sv
// Round-robin first-set-bit finder, scanning upward from a start index.
// Purely combinational; wraps modulo N.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] first,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    int j;
    j     = 0;
    valid = 1'b0;
    idx   = '0;
    // Descending offsets so the nearest request to 'first' wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(first) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/block_scheduler.sv
// Thread-block scheduler: latches a launch, hands block IDs to idle
// cores round-robin, retires simultaneous completions in one cycle.
module block_scheduler
  import block_scheduler_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int BLOCK_ID_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                abort,
  input  logic [BLOCK_ID_WIDTH:0]             num_blocks,
  input  logic [NUM_CORES-1:0]                core_done,
  output logic [NUM_CORES-1:0]                core_start,
  output logic [NUM_CORES-1:0]                core_reset,
  output logic [NUM_CORES*BLOCK_ID_WIDTH-1:0] core_block_id,
  output logic                                busy,
  output logic                                done,
  output logic                                aborted,
  output logic [BLOCK_ID_WIDTH:0]             blocks_done
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CW = BLOCK_ID_WIDTH + 1;
  localparam int BW = BLOCK_ID_WIDTH;

  sched_state_t state_q, state_d;

  logic [CW-1:0] num_q, num_d;
  logic [CW-1:0] disp_q, disp_d;
  logic [CW-1:0] ret_q, ret_d;

  logic [NUM_CORES-1:0] run_q, run_d;
  logic [NUM_CORES-1:0] fin;
  logic [MAX_CORES-1:0] fin_ext;

  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] pick;
  logic          pick_vld;
  logic          disp_en;

  logic [BW-1:0] id_q [NUM_CORES];
  logic [BW-1:0] id_d [NUM_CORES];

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic abrt_q, abrt_d;

  // Cores finishing this cycle are not offered to the picker, so a
  // freed core sees at least one cycle of reset before its next block.
  rr_picker #(
    .N  (NUM_CORES),
    .IW (IW)
  ) u_pick (
    .req   (~run_q),
    .first (rr_q),
    .valid (pick_vld),
    .idx   (pick)
  );

  assign fin     = run_q & core_done;
  assign fin_ext = MAX_CORES'(fin);
  assign disp_en = (state_q == RUN) && !abort
                && (disp_q < num_q) && pick_vld;

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    disp_d  = disp_q;
    ret_d   = ret_q;
    run_d   = run_q;
    rr_d    = rr_q;
    done_d  = done_q;
    abrt_d  = 1'b0;
    id_d    = id_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          num_d   = num_blocks;
          disp_d  = '0;
          ret_d   = '0;
          done_d  = 1'b0;
          rr_d    = '0;
          run_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          run_d   = '0;
          abrt_d  = 1'b1;
        end else begin
          run_d = run_q & ~fin;
          ret_d = ret_q + CW'(popcount(fin_ext));
          if (disp_en) begin
            run_d[pick] = 1'b1;
            id_d[pick]  = disp_q[BW-1:0];
            disp_d      = disp_q + CW'(1);
            rr_d = (pick == IW'(NUM_CORES - 1)) ? '0 : pick + IW'(1);
          end
          if (ret_d == num_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      num_q   <= '0;
      disp_q  <= '0;
      ret_q   <= '0;
      run_q   <= '0;
      rr_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) id_q[i] <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      disp_q  <= disp_d;
      ret_q   <= ret_d;
      run_q   <= run_d;
      rr_q    <= rr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
      for (int i = 0; i < NUM_CORES; i++) id_q[i] <= id_d[i];
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_id
    assign core_block_id[g*BW +: BW] = id_q[g];
  end

  assign core_start  = run_q;
  assign core_reset  = ~run_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = abrt_q;
  assign blocks_done = ret_q;

endmodule

// File: tb/tb_block_scheduler.sv
// Directed bench for block_scheduler with a block-ID scoreboard
// and a round-robin reference for the chosen core.
module tb_block_scheduler;

  localparam int NC = 4;
  localparam int BW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [BW:0]       num_blocks;
  logic [NC-1:0]     core_done;
  logic [NC-1:0]     core_start;
  logic [NC-1:0]     core_reset;
  logic [NC*BW-1:0]  core_block_id;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [BW:0]       blocks_done;

  int checks = 0;
  int errors = 0;
  int q[$];
  int rr_m = 0;
  int rises_total = 0;
  int cnt[NC];
  logic [NC-1:0] prev = '0;
  bit auto_en = 0;

  block_scheduler #(
    .NUM_CORES      (NC),
    .BLOCK_ID_WIDTH (BW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .num_blocks    (num_blocks),
    .core_done     (core_done),
    .core_start    (core_start),
    .core_reset    (core_reset),
    .core_block_id (core_block_id),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .blocks_done   (blocks_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard bookkeeping on the inputs about to be
  // sampled, the edge, then checks of any newly started core.
  task automatic step();
    logic [NC-1:0] rise;
    int nr;
    int exp_core;
    int j;
    int e;
    if (reset) begin
      q.delete();
      rr_m = 0;
    end else if (busy && abort) begin
      q.delete();
    end else if (start && !busy) begin
      q.delete();
      for (int b = 0; b < int'(num_blocks); b++) q.push_back(b);
      rr_m = 0;
    end
    @(posedge clk);
    @(negedge clk);
    rise = core_start & ~prev;
    nr = 0;
    for (int i = 0; i < NC; i++) begin
      if (rise[i]) begin
        nr++;
        rises_total++;
        exp_core = -1;
        for (int k = 0; k < NC; k++) begin
          j = (rr_m + k) % NC;
          if (!prev[j] && exp_core < 0) exp_core = j;
        end
        chk("rr_core", i, exp_core);
        rr_m = (i + 1) % NC;
        chk("sb_has_entry", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("blk_id", core_block_id[i*BW +: BW], e);
        end
      end
    end
    if (nr > 0) chk("one_dispatch", nr <= 1, 1);
    if (auto_en) begin
      for (int i = 0; i < NC; i++) begin
        if (core_start[i]) begin
          cnt[i]++;
          core_done[i] = (cnt[i] >= 3);
        end else begin
          cnt[i] = 0;
          core_done[i] = 1'b0;
        end
      end
    end
    prev = core_start;
  endtask

  initial begin
    int r0;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    num_blocks = '0;
    core_done = '0;
    for (int i = 0; i < NC; i++) cnt[i] = 0;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    chk("rst_core_reset", core_reset, 4'hF);
    chk("rst_core_start", core_start, 4'h0);
    chk("rst_ids", core_block_id, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_aborted", aborted, 1'b0);
    chk("rst_blocks_done", blocks_done, 9'd0);

    // Empty launch
    num_blocks = 9'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_busy", busy, 1'b1);
    chk("zero_done_early", done, 1'b0);
    step();
    chk("zero_done", done, 1'b1);
    chk("zero_busy_off", busy, 1'b0);
    chk("zero_core_start", core_start, 4'h0);
    chk("zero_core_reset", core_reset, 4'hF);

    // Five blocks, cores complete 3 cycles after start
    r0 = rises_total;
    num_blocks = 9'd5;
    auto_en = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (done) break;
      step();
    end
    auto_en = 0;
    core_done = '0;
    chk("auto_done", done, 1'b1);
    chk("auto_blocks_done", blocks_done, 9'd5);
    chk("auto_dispatches", rises_total - r0, 5);
    chk("auto_sb_empty", q.size(), 0);
    step();

    // Four blocks, all complete together
    num_blocks = 9'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("sim_restart_done_clr", done, 1'b0);
    step();
    chk("sim_start1", core_start, 4'b0001);
    step();
    chk("sim_start2", core_start, 4'b0011);
    step();
    chk("sim_start3", core_start, 4'b0111);
    step();
    chk("sim_start4", core_start, 4'b1111);
    chk("sim_bd_before", blocks_done, 9'd0);
    core_done = 4'hF;
    step();
    core_done = '0;
    chk("sim_bd_after", blocks_done, 9'd4);
    chk("sim_done", done, 1'b1);
    chk("sim_busy", busy, 1'b0);
    chk("sim_core_reset", core_reset, 4'hF);

    // Abort two cycles after the first dispatch
    num_blocks = 9'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abt_core_reset", core_reset, 4'hF);
    chk("abt_aborted", aborted, 1'b1);
    chk("abt_done", done, 1'b0);
    chk("abt_busy", busy, 1'b0);
    chk("abt_bd", blocks_done, 9'd0);
    step();
    chk("abt_pulse_once", aborted, 1'b0);
    num_blocks = 9'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("abt_re_start", core_start, 4'b0111);
    core_done = 4'b0111;
    step();
    core_done = '0;
    chk("abt_re_done", done, 1'b1);
    chk("abt_re_bd", blocks_done, 9'd3);
    chk("abt_re_sb", q.size(), 0);

    // Only core 1 ever completes
    num_blocks = 9'd8;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    step();
    for (int r = 0; r < 4; r++) begin
      core_done = 4'b0010;
      step();
      core_done = '0;
      chk("fair_gap_reset", core_reset[1], 1'b1);
      step();
      chk("fair_redispatch", core_start, 4'hF);
    end
    chk("fair_bd", blocks_done, 9'd4);
    chk("fair_sb", q.size(), 0);
    core_done = 4'hF;
    step();
    core_done = '0;
    chk("fair_bd_final", blocks_done, 9'd8);
    chk("fair_done", done, 1'b1);

    // Synchronous reset with three cores busy
    num_blocks = 9'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("mrst_pre", core_start, 4'b0111);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_core_reset", core_reset, 4'hF);
    chk("mrst_core_start", core_start, 4'h0);
    chk("mrst_ids", core_block_id, 32'h0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_bd", blocks_done, 9'd0);
    core_done = 4'hF;
    step();
    core_done = '0;
    chk("mrst_stray_bd", blocks_done, 9'd0);
    chk("mrst_stray_start", core_start, 4'h0);
    chk("mrst_stray_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
